// File: rtl/write_back_unit.sv
// Registered write-back stage: selects the ALU or load result, formats load lanes, and stalls
// while a load waits for memory. The register-file and flag writes appear one cycle later.
module write_back_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned FLAG_W = 4,
  parameter int unsigned OFF_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              mem_enable,
  input  logic              mem_ready,
  input  logic [1:0]        ld_size,
  input  logic              ld_signed,
  input  logic [OFF_W-1:0]  addr_lo,
  input  logic [REG_AW-1:0] Rd_in,
  input  logic              w_en,
  input  logic              s_in,
  input  logic [FLAG_W-1:0] cpsr_in,
  output logic [DATA_W-1:0] result,
  output logic [REG_AW-1:0] Rd,
  output logic              write,
  output logic [FLAG_W-1:0] flags,
  output logic              flags_write,
  output logic              fwd_valid,
  output logic              stall
);

  typedef enum logic [0:0] {StRun, StWait} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic                write_q, write_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic                flags_write_q, flags_write_d;

  // Op captured while its load data is outstanding.
  logic [REG_AW-1:0]   hold_rd_q, hold_rd_d;
  logic                hold_wen_q, hold_wen_d;
  logic                hold_s_q, hold_s_d;
  logic [FLAG_W-1:0]   hold_cpsr_q, hold_cpsr_d;
  logic [1:0]          hold_size_q, hold_size_d;
  logic                hold_signed_q, hold_signed_d;
  logic [OFF_W-1:0]    hold_off_q, hold_off_d;

  // Load formatter, fed from the live inputs in RUN and from the hold registers in WAIT.
  logic [1:0]          f_size;
  logic                f_signed;
  logic [OFF_W-1:0]    f_off;
  logic [OFF_W-1:0]    f_off_al;
  logic [OFF_W+2:0]    f_shamt;
  logic [DATA_W-1:0]   f_mask;
  logic [DATA_W-1:0]   f_shifted;
  logic                f_msb;
  logic [DATA_W-1:0]   f_data;

  always_comb begin
    f_size   = (state_q == StWait) ? hold_size_q   : ld_size;
    f_signed = (state_q == StWait) ? hold_signed_q : ld_signed;
    f_off    = (state_q == StWait) ? hold_off_q    : addr_lo;
    f_off_al = '0;
    f_mask   = '1;
    case (f_size)
      2'b00: begin
        f_off_al = f_off;
        f_mask   = DATA_W'(64'hFF);
      end
      2'b01: begin
        f_off_al = f_off & ~OFF_W'(1);
        f_mask   = DATA_W'(64'hFFFF);
      end
      2'b10: begin
        f_off_al = f_off & ~OFF_W'(3);
        f_mask   = DATA_W'(64'hFFFF_FFFF);
      end
      default: begin
        f_off_al = '0;
        f_mask   = '1;
      end
    endcase
    f_shamt   = {f_off_al, 3'b000};
    f_shifted = data_in >> f_shamt;
    // Top set bit of the mask marks the lane MSB.
    f_msb     = |(f_shifted & (f_mask ^ (f_mask >> 1)));
    f_data    = (f_signed && f_msb) ? (f_shifted | ~f_mask) : (f_shifted & f_mask);
  end

  always_comb begin
    state_d       = state_q;
    result_d      = result_q;
    rd_d          = rd_q;
    write_d       = 1'b0;
    flags_d       = flags_q;
    flags_write_d = 1'b0;
    hold_rd_d     = hold_rd_q;
    hold_wen_d    = hold_wen_q;
    hold_s_d      = hold_s_q;
    hold_cpsr_d   = hold_cpsr_q;
    hold_size_d   = hold_size_q;
    hold_signed_d = hold_signed_q;
    hold_off_d    = hold_off_q;

    case (state_q)
      StRun: begin
        if (in_valid) begin
          if (mem_enable && !mem_ready) begin
            hold_rd_d     = Rd_in;
            hold_wen_d    = w_en;
            hold_s_d      = s_in;
            hold_cpsr_d   = cpsr_in;
            hold_size_d   = ld_size;
            hold_signed_d = ld_signed;
            hold_off_d    = addr_lo;
            state_d       = StWait;
          end else begin
            result_d      = mem_enable ? f_data : alu_in;
            rd_d          = Rd_in;
            write_d       = w_en;
            flags_write_d = s_in;
            if (s_in) flags_d = cpsr_in;
          end
        end
      end
      StWait: begin
        if (mem_ready) begin
          result_d      = f_data;
          rd_d          = hold_rd_q;
          write_d       = hold_wen_q;
          flags_write_d = hold_s_q;
          if (hold_s_q) flags_d = hold_cpsr_q;
          state_d       = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StRun;
      result_q      <= '0;
      rd_q          <= '0;
      write_q       <= 1'b0;
      flags_q       <= '0;
      flags_write_q <= 1'b0;
      hold_rd_q     <= '0;
      hold_wen_q    <= 1'b0;
      hold_s_q      <= 1'b0;
      hold_cpsr_q   <= '0;
      hold_size_q   <= 2'b00;
      hold_signed_q <= 1'b0;
      hold_off_q    <= '0;
    end else begin
      state_q       <= state_d;
      result_q      <= result_d;
      rd_q          <= rd_d;
      write_q       <= write_d;
      flags_q       <= flags_d;
      flags_write_q <= flags_write_d;
      hold_rd_q     <= hold_rd_d;
      hold_wen_q    <= hold_wen_d;
      hold_s_q      <= hold_s_d;
      hold_cpsr_q   <= hold_cpsr_d;
      hold_size_q   <= hold_size_d;
      hold_signed_q <= hold_signed_d;
      hold_off_q    <= hold_off_d;
    end
  end

  assign in_ready    = (state_q == StRun);
  assign stall       = ~in_ready;
  assign result      = result_q;
  assign Rd          = rd_q;
  assign write       = write_q;
  assign flags       = flags_q;
  assign flags_write = flags_write_q;
  assign fwd_valid   = write_q;

endmodule

// File: tb/tb_write_back_unit.sv
// Bench for write_back_unit: 32- and 64-bit instances share one stimulus stream and are checked
// every cycle against a transaction-level model, plus hand-computed literal expectations.
module tb_write_back_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, mem_enable, mem_ready, ld_signed, w_en, s_in;
  logic [63:0] alu, data;
  logic [1:0]  ld_size;
  logic [2:0]  addr;
  logic [3:0]  rd_in, cpsr;

  logic [31:0] res32;
  logic [63:0] res64;
  logic [3:0]  rd32, rd64, fl32, fl64;
  logic        wr32, wr64, fw32, fw64, fv32, fv64, rdy32, rdy64, st32, st64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  write_back_unit #(.DATA_W(32), .REG_AW(4), .FLAG_W(4), .OFF_W(2)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
    .alu_in(alu[31:0]), .data_in(data[31:0]), .mem_enable(mem_enable), .mem_ready(mem_ready),
    .ld_size(ld_size), .ld_signed(ld_signed), .addr_lo(addr[1:0]), .Rd_in(rd_in),
    .w_en(w_en), .s_in(s_in), .cpsr_in(cpsr), .result(res32), .Rd(rd32), .write(wr32),
    .flags(fl32), .flags_write(fw32), .fwd_valid(fv32), .stall(st32)
  );

  write_back_unit #(.DATA_W(64), .REG_AW(4), .FLAG_W(4), .OFF_W(3)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64),
    .alu_in(alu), .data_in(data), .mem_enable(mem_enable), .mem_ready(mem_ready),
    .ld_size(ld_size), .ld_signed(ld_signed), .addr_lo(addr), .Rd_in(rd_in),
    .w_en(w_en), .s_in(s_in), .cpsr_in(cpsr), .result(res64), .Rd(rd64), .write(wr64),
    .flags(fl64), .flags_write(fw64), .fwd_valid(fv64), .stall(st64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Little-endian lane extraction with plain arithmetic: pick nb bytes at an nb-aligned offset.
  function automatic logic [63:0] fmt(input logic [63:0] d, input int w, input logic [1:0] size,
                                      input logic sgn, input int off);
    int nb;
    int base;
    logic [63:0] lane;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : w / 8;
    if (nb > w / 8) nb = w / 8;
    base = ((off % (w / 8)) / nb) * nb;
    lane = d >> (8 * base);
    if (nb < 8) begin
      lane = lane & ((64'd1 << (8 * nb)) - 64'd1);
      if (sgn && lane[8 * nb - 1]) lane = lane - (64'd1 << (8 * nb));
    end
    if (w == 32) lane = lane & 64'hFFFF_FFFF;
    return lane;
  endfunction

  // Model: pending load (if any) and the outputs the register file should see.
  logic        m_busy;
  logic [3:0]  m_hrd, m_hcpsr;
  logic        m_hwen, m_hs, m_hsgn;
  logic [1:0]  m_hsize;
  int          m_hoff;
  logic [63:0] e_res32, e_res64;
  logic [3:0]  e_rd, e_flags;
  logic        e_write, e_fw;

  task automatic complete(input logic is_load, input logic [1:0] sz, input logic sg, input int off,
                          input logic [3:0] rd, input logic we, input logic s,
                          input logic [3:0] c);
    e_res32 = is_load ? fmt(data, 32, sz, sg, off) : {32'd0, alu[31:0]};
    e_res64 = is_load ? fmt(data, 64, sz, sg, off) : alu;
    e_rd    = rd;
    e_write = we;
    e_fw    = s;
    if (s) e_flags = c;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0; e_res32 = '0; e_res64 = '0; e_rd = '0; e_flags = '0;
      e_write = 1'b0; e_fw = 1'b0;
    end else begin
      e_write = 1'b0;
      e_fw    = 1'b0;
      if (!m_busy) begin
        if (in_valid) begin
          if (mem_enable && !mem_ready) begin
            m_busy = 1'b1; m_hrd = rd_in; m_hwen = w_en; m_hs = s_in; m_hcpsr = cpsr;
            m_hsize = ld_size; m_hsgn = ld_signed; m_hoff = int'(addr);
          end else begin
            complete(mem_enable, ld_size, ld_signed, int'(addr), rd_in, w_en, s_in, cpsr);
          end
        end
      end else if (mem_ready) begin
        m_busy = 1'b0;
        complete(1'b1, m_hsize, m_hsgn, m_hoff, m_hrd, m_hwen, m_hs, m_hcpsr);
      end
    end
  end

  always @(negedge clk) begin
    chk("result32", {32'd0, res32}, e_res32);
    chk("result64", res64, e_res64);
    chk("rd32", {60'd0, rd32}, {60'd0, e_rd});
    chk("rd64", {60'd0, rd64}, {60'd0, e_rd});
    chk("write32", {63'd0, wr32}, {63'd0, e_write});
    chk("write64", {63'd0, wr64}, {63'd0, e_write});
    chk("fwd32", {63'd0, fv32}, {63'd0, e_write});
    chk("fwd64", {63'd0, fv64}, {63'd0, e_write});
    chk("flags32", {60'd0, fl32}, {60'd0, e_flags});
    chk("flags64", {60'd0, fl64}, {60'd0, e_flags});
    chk("flags_write32", {63'd0, fw32}, {63'd0, e_fw});
    chk("flags_write64", {63'd0, fw64}, {63'd0, e_fw});
    chk("in_ready32", {63'd0, rdy32}, {63'd0, !m_busy});
    chk("in_ready64", {63'd0, rdy64}, {63'd0, !m_busy});
    chk("stall32", {63'd0, st32}, {63'd0, m_busy});
    chk("stall64", {63'd0, st64}, {63'd0, m_busy});
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic alu_op(input logic [63:0] a, input logic [3:0] rd, input logic we,
                        input logic s, input logic [3:0] c);
    in_valid = 1'b1; mem_enable = 1'b0; mem_ready = 1'b0; alu = a; rd_in = rd;
    w_en = we; s_in = s; cpsr = c;
  endtask

  task automatic ld_op(input logic [63:0] d, input logic [1:0] sz, input logic sg,
                       input logic [2:0] a, input logic rdy, input logic [3:0] rd);
    in_valid = 1'b1; mem_enable = 1'b1; mem_ready = rdy; data = d; ld_size = sz;
    ld_signed = sg; addr = a; rd_in = rd; w_en = 1'b1; s_in = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; mem_enable = 1'b0; mem_ready = 1'b0; ld_signed = 1'b0;
    w_en = 1'b0; s_in = 1'b0; alu = '0; data = '0; ld_size = 2'b00; addr = '0;
    rd_in = '0; cpsr = '0;
    cyc(); cyc();
    reset = 1'b0;
    chk("lit_reset_ready", {63'd0, rdy32}, 64'd1);
    chk("lit_reset_result", {32'd0, res32}, 64'd0);

    // Single ALU op
    alu_op(64'h0000_1234, 4'd5, 1'b1, 1'b0, 4'd0);
    cyc();
    chk("lit_alu_result", {32'd0, res32}, 64'h1234);
    chk("lit_alu_rd", {60'd0, rd32}, 64'd5);
    chk("lit_alu_write", {63'd0, wr32}, 64'd1);
    in_valid = 1'b0;
    cyc();
    chk("lit_alu_write_pulse", {63'd0, wr32}, 64'd0);

    // Byte loads, data ready at accept
    ld_op(64'h8000_7F00, 2'b00, 1'b1, 3'd3, 1'b1, 4'd2);
    cyc();
    chk("lit_sbyte", {32'd0, res32}, 64'hFFFF_FF80);
    ld_op(64'h8000_7F00, 2'b00, 1'b0, 3'd1, 1'b1, 4'd2);
    cyc();
    chk("lit_ubyte", {32'd0, res32}, 64'h7F);

    // Half load with three stall cycles; Rd_in changes while waiting
    ld_op(64'h8001_0002, 2'b01, 1'b1, 3'd2, 1'b0, 4'd7);
    cyc();
    chk("lit_wait_stall1", {63'd0, st32}, 64'd1);
    rd_in = 4'd9;
    cyc();
    chk("lit_wait_stall2", {63'd0, st32}, 64'd1);
    cyc();
    chk("lit_wait_stall3", {63'd0, st32}, 64'd1);
    chk("lit_wait_nowrite", {63'd0, wr32}, 64'd0);
    mem_ready = 1'b1;
    cyc();
    in_valid = 1'b0; mem_enable = 1'b0; mem_ready = 1'b0;
    chk("lit_half_result", {32'd0, res32}, 64'hFFFF_8001);
    chk("lit_half_rd", {60'd0, rd32}, 64'd7);
    chk("lit_half_write", {63'd0, wr32}, 64'd1);
    cyc();
    chk("lit_half_ready_after", {63'd0, rdy32}, 64'd1);

    // Back-to-back ALU ops, flags on the second
    alu_op(64'h11, 4'd1, 1'b1, 1'b0, 4'd0);
    cyc();
    chk("lit_b2b_w1", {63'd0, wr32}, 64'd1);
    alu_op(64'h22, 4'd2, 1'b1, 1'b1, 4'b1010);
    cyc();
    chk("lit_b2b_w2", {63'd0, wr32}, 64'd1);
    chk("lit_b2b_fw2", {63'd0, fw32}, 64'd1);
    alu_op(64'h33, 4'd3, 1'b1, 1'b0, 4'd0);
    cyc();
    chk("lit_b2b_w3", {63'd0, wr32}, 64'd1);
    chk("lit_b2b_fw3", {63'd0, fw32}, 64'd0);
    chk("lit_b2b_flags", {60'd0, fl32}, 64'hA);

    // Flags-only op, stray mem_ready while idle
    alu_op(64'h55, 4'd6, 1'b0, 1'b1, 4'b0101);
    cyc();
    chk("lit_fonly_write", {63'd0, wr32}, 64'd0);
    chk("lit_fonly_fw", {63'd0, fw32}, 64'd1);
    chk("lit_fonly_rd", {60'd0, rd32}, 64'd6);
    in_valid = 1'b0; mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;

    // Reset while waiting discards the held load
    ld_op(64'hFFFF_FFFF, 2'b10, 1'b0, 3'd0, 1'b0, 4'd8);
    cyc();
    in_valid = 1'b0; reset = 1'b1; mem_ready = 1'b1;
    cyc();
    reset = 1'b0; mem_ready = 1'b0;
    chk("lit_rst_wait_ready", {63'd0, rdy32}, 64'd1);
    chk("lit_rst_wait_write", {63'd0, wr32}, 64'd0);
    cyc();
    chk("lit_rst_wait_nostrobe", {63'd0, wr32}, 64'd0);
    alu_op(64'hCAFE, 4'd4, 1'b1, 1'b0, 4'd0);
    cyc();
    chk("lit_post_rst_result", {32'd0, res32}, 64'hCAFE);
    in_valid = 1'b0;
    cyc();

    // 64-bit lanes
    ld_op(64'h8765_4321_0000_0000, 2'b10, 1'b1, 3'd4, 1'b1, 4'd3);
    cyc();
    chk("lit_w64_word", res64, 64'hFFFF_FFFF_8765_4321);
    ld_op(64'h1122_3344_5566_7788, 2'b11, 1'b1, 3'd5, 1'b1, 4'd3);
    cyc();
    chk("lit_w64_full", res64, 64'h1122_3344_5566_7788);
    chk("lit_w32_full", {32'd0, res32}, 64'h5566_7788);
    ld_op(64'h1122_3344_F566_7788, 2'b01, 1'b1, 3'd7, 1'b1, 4'd3);
    cyc();
    chk("lit_w64_half", res64, 64'h0000_0000_0000_1122);
    in_valid = 1'b0; mem_enable = 1'b0; mem_ready = 1'b0;
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
